gate_mux_arbiter: RTL and testbench



---
 rtl/gate_mux_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_gate_mux_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_mux_arbiter.sv
// Round-robin arbiter sharing one mux-based logic-gate evaluator among NREQ
// requesters; result is registered and returned with the winner's ID.

module mux_8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);
  assign y = i[s];
endmodule

module gate_mux_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_a,
  input  logic [NREQ-1:0]      req_b,
  input  logic [3*NREQ-1:0]    req_op,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic                 rsp_y,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  input  logic                 rsp_ready,
  output logic [CNTW-1:0]      op_count
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] winner_s;
  logic [IDW-1:0] idx_s;
  logic           found_s;
  logic           can_accept_s;
  logic           xfer_s;
  logic           drain_s;
  logic [2:0]     op_arr_s [NREQ];
  logic           a_s;
  logic           b_s;
  logic [2:0]     op_s;
  logic [3:0]     tt_s;
  logic [7:0]     mux_in_s;
  logic           y_s;
  logic           err_s;
  logic           rsp_y_r;
  logic           rsp_err_r;
  logic [IDW-1:0] rsp_id_r;
  logic [CNTW-1:0] cnt_r;

  // Truth table indexed by {a,b}; reserved opcode yields all zeros.
  function automatic logic [3:0] truth_table(input logic [2:0] op);
    case (op)
      3'b000:  truth_table = 4'b1000;
      3'b001:  truth_table = 4'b1110;
      3'b010:  truth_table = 4'b0011;
      3'b011:  truth_table = 4'b0111;
      3'b100:  truth_table = 4'b0001;
      3'b101:  truth_table = 4'b0110;
      3'b110:  truth_table = 4'b1001;
      default: truth_table = 4'b0000;
    endcase
  endfunction

  // The mux select carries a trailing 0, so table entries land on even inputs.
  function automatic logic [7:0] expand_tt(input logic [3:0] tt);
    expand_tt = {1'b0, tt[3], 1'b0, tt[2], 1'b0, tt[1], 1'b0, tt[0]};
  endfunction

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_op_unpack
      assign op_arr_s[g] = req_op[3*g+2:3*g];
    end
  endgenerate

  // Round-robin search: first valid requester from the pointer upward, wrapping.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    idx_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign can_accept_s = (state_r == EMPTY) || ((state_r == FULL) && rsp_ready);
  assign xfer_s       = can_accept_s && found_s && !rst;
  assign drain_s      = (state_r == FULL) && rsp_ready;

  // One-hot grant strobe to the winning requester.
  always_comb begin
    req_ready = '0;
    if (xfer_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign a_s      = req_a[winner_s];
  assign b_s      = req_b[winner_s];
  assign op_s     = op_arr_s[winner_s];
  assign tt_s     = truth_table(op_s);
  assign mux_in_s = expand_tt(tt_s);
  assign err_s    = (op_s == 3'b111);

  mux_8x1 u_mux (
    .i (mux_in_s),
    .s ({a_s, b_s, 1'b0}),
    .y (y_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a drain with a simultaneous transfer stays FULL.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (xfer_s) state_nxt_s = FULL;
        else        state_nxt_s = EMPTY;
      end
      FULL: begin
        if (rsp_ready && !xfer_s) state_nxt_s = EMPTY;
        else                      state_nxt_s = FULL;
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Output decode from registered state and result fields.
  always_comb begin
    rsp_valid = (state_r == FULL);
    rsp_y     = rsp_y_r;
    rsp_id    = rsp_id_r;
    rsp_err   = rsp_err_r;
    op_count  = cnt_r;
  end

  // Result register, round-robin pointer and drained-response counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_y_r   <= 1'b0;
      rsp_err_r <= 1'b0;
      rsp_id_r  <= '0;
      ptr_r     <= '0;
      cnt_r     <= '0;
    end else begin
      if (xfer_s) begin
        rsp_y_r   <= y_s;
        rsp_err_r <= err_s;
        rsp_id_r  <= winner_s;
        if (winner_s == IDW'(NREQ-1)) ptr_r <= '0;
        else                          ptr_r <= winner_s + IDW'(1'b1);
      end else begin
        ptr_r <= ptr_r;
      end
      if (drain_s) cnt_r <= cnt_r + CNTW'(1'b1);
      else         cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_gate_mux_arbiter.sv
// Randomized and directed bench for gate_mux_arbiter against a behavioural
// arbitration/gate model.

module tb_gate_mux_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_a = '0;
  logic [NREQ-1:0]   req_b = '0;
  logic [3*NREQ-1:0] req_op = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_y;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              rsp_ready = 1'b0;
  logic [CNTW-1:0]   op_count;

  gate_mux_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit m_full;
  bit m_y;
  bit m_err;
  int m_id;
  int m_ptr;
  int m_cnt;
  logic [NREQ-1:0] last_grant = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_gate(input int op, input bit a, input bit b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return !a;
      3: return !(a & b);
      4: return !(a | b);
      5: return a ^ b;
      6: return !(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 0; m_y = 0; m_err = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // One clock: check the grant mid-cycle, then the registered result after the edge.
  task automatic cycle();
    int win;
    int idx;
    int op;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    win = -1;
    if (!m_full || rsp_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    exp_rdy = (win >= 0) ? NREQ'(1 << win) : '0;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    last_grant = exp_rdy;
    @(posedge clk);
    #1;
    if (m_full && rsp_ready) m_cnt = (m_cnt + 1) % (1 << CNTW);
    if (win >= 0) begin
      op     = int'(req_op[3*win +: 3]);
      m_full = 1;
      m_id   = win;
      m_err  = (op == 7);
      m_y    = ref_gate(op, req_a[win], req_b[win]);
      m_ptr  = (win + 1) % NREQ;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full) begin
      check_val("rsp_y", 32'(rsp_y), 32'(m_y));
      check_val("rsp_id", 32'(rsp_id), 32'(m_id));
      check_val("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    check_val("op_count", 32'(op_count), 32'(m_cnt));
  endtask

  task automatic do_reset();
    req_valid = '1;
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_val("rst_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_count", 32'(op_count), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_y", 32'(rsp_y), 32'd0);
    check_val("rst_id", 32'(rsp_id), 32'd0);
    check_val("rst_err", 32'(rsp_err), 32'd0);
    model_reset();
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Requester 0 alone: every opcode over every operand pair.
    rsp_ready = 1'b1;
    for (int op = 0; op < 7; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        req_valid    = 4'b0001;
        req_a[0]     = ab[1];
        req_b[0]     = ab[0];
        req_op[2:0]  = 3'(op);
        cycle();
      end
    end
    req_valid = '0;
    cycle();
    check_val("opcnt28", 32'(op_count), 32'd28);

    // All four held: round-robin one grant per cycle.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_a     = 4'($urandom);
    req_b     = 4'($urandom);
    req_op    = 12'($urandom) & 12'b110_110_110_110;
    repeat (12) cycle();

    // Backpressure: nothing granted and outputs frozen while the consumer stalls.
    rsp_ready = 1'b0;
    repeat (5) cycle();
    rsp_ready = 1'b1;
    repeat (2) cycle();

    // Reserved opcode from requester 2.
    req_valid     = 4'b0100;
    req_op[8:6]   = 3'b111;
    req_a[2]      = 1'b1;
    req_b[2]      = 1'b1;
    cycle();
    check_val("resv_y", 32'(rsp_y), 32'd0);
    check_val("resv_err", 32'(rsp_err), 32'd1);
    check_val("resv_id", 32'(rsp_id), 32'd2);
    req_valid = '0;
    cycle();

    // Reset while FULL and stalled, then grant from pointer 0.
    req_valid = 4'b0001;
    req_op[2:0] = 3'b101;
    rsp_ready = 1'b0;
    repeat (2) cycle();
    do_reset();
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    cycle();
    check_val("post_rst_id", 32'(rsp_id), 32'd1);

    // Randomized traffic honouring the hold-until-granted rule.
    last_grant = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(req_valid[i] && !last_grant[i])) begin
          req_valid[i]     = 1'($urandom_range(0, 1));
          req_a[i]         = 1'($urandom_range(0, 1));
          req_b[i]         = 1'($urandom_range(0, 1));
          req_op[3*i +: 3] = 3'($urandom_range(0, 7));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Counter wrap after 256 drained responses.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    repeat (256) cycle();
    req_valid = '0;
    cycle();
    check_val("op_wrap", 32'(op_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
